fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction buffer.
- Holds the PC and issues one aligned fetch request per 8-byte fetch group to the ICache. Returns one or two instructions with addresses and per-slot valids into the buffer.
- Honours buffer back-pressure (buffer_full) and pipeline flush/redirect, discarding any in-flight ICache response that belongs to a squashed path.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC loaded on reset.
- ADDR_W, 32, address width.
- INST_W, 32, instruction width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush_i  in  1  squash the current fetch path.
- flush_pc_i  in  ADDR_W  redirect target; bits [1:0] are ignored and treated as 0.
- buffer_full_i  in  1  instruction buffer near-full; blocks new requests.
- icache_req_o  out  1  fetch request valid.
- icache_addr_o  out  ADDR_W  fetch address; equals the current PC.
- icache_ack_i  in  1  ICache accepted the request this cycle.
- icache_rvalid_i  in  1  response data valid; one pulse per accepted request.
- icache_rdata1_i  in  INST_W  instruction at the requested address.
- icache_rdata2_i  in  INST_W  instruction at requested address + 4.
- inst1_o  out  INST_W  slot-1 instruction to the buffer.
- inst2_o  out  INST_W  slot-2 instruction to the buffer.
- inst1_addr_o  out  ADDR_W  slot-1 PC.
- inst2_addr_o  out  ADDR_W  slot-2 PC.
- inst1_valid_o  out  1  slot 1 valid.
- inst2_valid_o  out  1  slot 2 valid; never 1 unless inst1_valid_o is 1.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, state=REQ.
  - All out valids=0, icache_req_o=0; inst/addr outputs=0.
- FSM states: REQ, WAIT, DISCARD. At most one request is outstanding.
- REQ:
  - icache_req_o = !buffer_full_i && !flush_i. icache_addr_o = pc.
  - On req && ack: latch req_pc=pc; pc <= next_pc; go to WAIT.
  - next_pc = pc+8 if pc[2]==0 (two instructions fetched), else pc+4 (one instruction, upper word of the group). Arithmetic is mod 2^ADDR_W, so 32'hFFFF_FFF8+8 wraps to 0.
- WAIT:
  - On rvalid with no flush: go to REQ. Next cycle, exactly one cycle of output:
    - inst1_o=rdata1, inst1_addr_o=req_pc, inst1_valid_o=1.
    - inst2_o=rdata2, inst2_addr_o=req_pc+4, inst2_valid_o=!req_pc[2].
  - Output latency is therefore 1 cycle from rvalid. Valids self-clear the following cycle.
- Response delivery ignores buffer_full_i. The buffer reserves slack for the one outstanding group; only new requests are gated.
- Flush (highest priority, every state): pc <= {flush_pc_i[ADDR_W-1:2],2'b00}; next-edge out valids=0.
  - REQ, no ack in flight: stay in REQ. icache_req_o is forced 0 in the flush cycle and the request restarts next cycle at flush_pc.
  - WAIT with no rvalid in the same cycle: go to DISCARD.
  - WAIT with rvalid in the same cycle: data is dropped; go to REQ.
  - DISCARD: stays in DISCARD; pc takes the newest flush_pc.
- DISCARD: on rvalid, drop the data (no out valids) and go to REQ. No request is issued while in DISCARD.
- Reset mid-operation: immediate return to reset values. The ICache is reset by the same rst, so no stale response is expected.
- Redirects occur only via flush; there is no branch prediction in this block.

Decomposition:
- Shared header (defines.v): RESET_PC value, InstBus/InstAddrBus widths, fetch state encodings (FETCH_REQ/FETCH_WAIT/FETCH_DISCARD), Valid/Invalid constants.
- One natural sub-module, fetch_pc_gen: combinational next_pc and inst2-valid computation from pc[2]. The FSM and registers stay in fetch_unit.

Test Plan:
- Reset release, ack immediate, rvalid 2 cycles later with rdata1=A, rdata2=B -> req addr 0xBFC00000; one cycle later inst1=A@0xBFC00000, inst2=B@0xBFC00004, both valid; next req addr 0xBFC00008.
- Flush with flush_pc=0x80000004 while idle, then response -> req at 0x80000004; output inst1 valid @0x80000004, inst2_valid=0; next req 0x80000008.
- Flush during WAIT (rvalid 3 cycles later) -> DISCARD; that response produces no out valids; next req at flush_pc; no second request while discarding.
- flush and rvalid in the same cycle -> no out valids; req at flush_pc on the next cycle.
- buffer_full_i=1 in REQ for 4 cycles -> icache_req_o=0 throughout. With full asserted during WAIT, the response is still delivered once.
- pc=0xFFFFFFF8, ack + response -> outputs @0xFFFFFFF8/0xFFFFFFFC; next req addr 0x00000000.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants: reset PC, bus widths, FSM encodings and valid levels.
// Imported by the fetch unit and its PC generator.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam int unsigned INST_BUS_W      = 32;
    localparam int unsigned INST_ADDR_BUS_W = 32;

    localparam logic [1:0] FETCH_REQ     = 2'd0;
    localparam logic [1:0] FETCH_WAIT    = 2'd1;
    localparam logic [1:0] FETCH_DISCARD = 2'd2;

    localparam logic VALID   = 1'b1;
    localparam logic INVALID = 1'b0;

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC and slot-2 validity for an 8-byte fetch group starting at pc.
// A group starting on the upper word holds a single instruction.
module fetch_pc_gen
    import fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = INST_ADDR_BUS_W
) (
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] next_pc,
    output logic              two_valid
);

    always_comb begin
        two_valid = pc[2] ? INVALID : VALID;
        next_pc   = pc + (pc[2] ? ADDR_W'(4) : ADDR_W'(8));
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding aligned ICache request per fetch group,
// registered one/two-instruction delivery, and flush handling that squashes stale responses.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned        ADDR_W   = INST_ADDR_BUS_W,
    parameter int unsigned        INST_W   = INST_BUS_W,
    parameter logic [ADDR_W-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    input  logic              buffer_full_i,
    output logic              icache_req_o,
    output logic [ADDR_W-1:0] icache_addr_o,
    input  logic              icache_ack_i,
    input  logic              icache_rvalid_i,
    input  logic [INST_W-1:0] icache_rdata1_i,
    input  logic [INST_W-1:0] icache_rdata2_i,
    output logic [INST_W-1:0] inst1_o,
    output logic [INST_W-1:0] inst2_o,
    output logic [ADDR_W-1:0] inst1_addr_o,
    output logic [ADDR_W-1:0] inst2_addr_o,
    output logic              inst1_valid_o,
    output logic              inst2_valid_o
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              req_two_q, req_two_d;
    logic [ADDR_W-1:0] next_pc;
    logic              two_valid;
    logic              deliver;

    logic [INST_W-1:0] inst1_q, inst2_q;
    logic [ADDR_W-1:0] inst1_addr_q, inst2_addr_q;
    logic              inst1_valid_q, inst2_valid_q;

    logic unused_flush_bits;
    assign unused_flush_bits = ^flush_pc_i[1:0];

    fetch_pc_gen #(
        .ADDR_W (ADDR_W)
    ) u_pc_gen (
        .pc        (pc_q),
        .next_pc   (next_pc),
        .two_valid (two_valid)
    );

    assign icache_req_o  = rst && (state_q == FETCH_REQ) && !buffer_full_i && !flush_i;
    assign icache_addr_o = pc_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        req_two_d = req_two_q;
        deliver   = 1'b0;
        if (flush_i) begin
            pc_d = {flush_pc_i[ADDR_W-1:2], 2'b00};
            // A response arriving with the flush is already accounted for; otherwise wait it out.
            if (state_q == FETCH_WAIT) begin
                state_d = icache_rvalid_i ? FETCH_REQ : FETCH_DISCARD;
            end
        end else begin
            unique case (state_q)
                FETCH_REQ: begin
                    if (icache_req_o && icache_ack_i) begin
                        req_pc_d  = pc_q;
                        req_two_d = two_valid;
                        pc_d      = next_pc;
                        state_d   = FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (icache_rvalid_i) begin
                        deliver = 1'b1;
                        state_d = FETCH_REQ;
                    end
                end
                FETCH_DISCARD: begin
                    if (icache_rvalid_i) begin
                        state_d = FETCH_REQ;
                    end
                end
                default: state_d = FETCH_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= FETCH_REQ;
            pc_q          <= RESET_PC;
            req_pc_q      <= '0;
            req_two_q     <= INVALID;
            inst1_q       <= '0;
            inst2_q       <= '0;
            inst1_addr_q  <= '0;
            inst2_addr_q  <= '0;
            inst1_valid_q <= INVALID;
            inst2_valid_q <= INVALID;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            req_two_q     <= req_two_d;
            inst1_valid_q <= deliver;
            inst2_valid_q <= deliver && req_two_q;
            if (deliver) begin
                inst1_q      <= icache_rdata1_i;
                inst2_q      <= icache_rdata2_i;
                inst1_addr_q <= req_pc_q;
                inst2_addr_q <= req_pc_q + ADDR_W'(4);
            end
        end
    end

    assign inst1_o       = inst1_q;
    assign inst2_o       = inst2_q;
    assign inst1_addr_o  = inst1_addr_q;
    assign inst2_addr_o  = inst2_addr_q;
    assign inst1_valid_o = inst1_valid_q;
    assign inst2_valid_o = inst2_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected deliveries are queued when a response is driven
// and compared by a monitor whenever slot 1 reports valid.
module tb_fetch_unit;

    typedef struct {
        logic [31:0] inst1;
        logic [31:0] inst2;
        logic [31:0] addr1;
        logic [31:0] addr2;
        logic        v2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] flush_pc_i = '0;
    logic        buffer_full_i = 1'b0;
    logic        icache_req_o;
    logic [31:0] icache_addr_o;
    logic        icache_ack_i = 1'b0;
    logic        icache_rvalid_i = 1'b0;
    logic [31:0] icache_rdata1_i = '0;
    logic [31:0] icache_rdata2_i = '0;
    logic [31:0] inst1_o, inst2_o, inst1_addr_o, inst2_addr_o;
    logic        inst1_valid_o, inst2_valid_o;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush_i),
        .flush_pc_i      (flush_pc_i),
        .buffer_full_i   (buffer_full_i),
        .icache_req_o    (icache_req_o),
        .icache_addr_o   (icache_addr_o),
        .icache_ack_i    (icache_ack_i),
        .icache_rvalid_i (icache_rvalid_i),
        .icache_rdata1_i (icache_rdata1_i),
        .icache_rdata2_i (icache_rdata2_i),
        .inst1_o         (inst1_o),
        .inst2_o         (inst2_o),
        .inst1_addr_o    (inst1_addr_o),
        .inst2_addr_o    (inst2_addr_o),
        .inst1_valid_o   (inst1_valid_o),
        .inst2_valid_o   (inst2_valid_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Monitor: every valid delivery must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && inst1_valid_o) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_valid", 32'(inst1_valid_o), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("inst1", inst1_o, e.inst1);
                check_eq("inst1_addr", inst1_addr_o, e.addr1);
                check_eq("inst2_valid", 32'(inst2_valid_o), 32'(e.v2));
                if (e.v2) begin
                    check_eq("inst2", inst2_o, e.inst2);
                    check_eq("inst2_addr", inst2_addr_o, e.addr2);
                end
            end
        end else if (rst) begin
            check_eq("inst2_without_inst1", 32'(inst2_valid_o), 32'd0);
        end
    end

    // Request accepted immediately, response after lat cycles, expectation queued on rvalid.
    task automatic fetch_group(input logic [31:0] addr, input logic [31:0] a,
                               input logic [31:0] b, input int lat);
        exp_t e;
        @(negedge clk);
        icache_ack_i = 1'b1;
        #1;
        check_eq("req", 32'(icache_req_o), 32'd1);
        check_eq("req_addr", icache_addr_o, addr);
        @(negedge clk);
        icache_ack_i = 1'b0;
        #1;
        check_eq("no_req_in_wait", 32'(icache_req_o), 32'd0);
        repeat (lat - 1) @(negedge clk);
        icache_rvalid_i = 1'b1;
        icache_rdata1_i = a;
        icache_rdata2_i = b;
        e.inst1 = a;
        e.inst2 = b;
        e.addr1 = addr;
        e.addr2 = addr + 32'd4;
        e.v2    = ~addr[2];
        sb.push_back(e);
        @(negedge clk);
        icache_rvalid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_req", 32'(icache_req_o), 32'd0);
        check_eq("rst_valid1", 32'(inst1_valid_o), 32'd0);
        check_eq("rst_valid2", 32'(inst2_valid_o), 32'd0);
        check_eq("rst_inst1", inst1_o, 32'd0);
        check_eq("rst_addr1", inst1_addr_o, 32'd0);
        check_eq("rst_pc", icache_addr_o, 32'hBFC0_0000);
        rst = 1'b1;

        // Basic two-instruction group from the reset PC.
        fetch_group(32'hBFC0_0000, 32'hAAAA_0001, 32'hBBBB_0002, 2);

        // Flush while idle to an upper-word target.
        @(negedge clk);
        flush_i    = 1'b1;
        flush_pc_i = 32'h8000_0004;
        #1;
        check_eq("req_addr_after_group", icache_addr_o, 32'hBFC0_0008);
        check_eq("flush_forces_no_req", 32'(icache_req_o), 32'd0);
        @(negedge clk);
        flush_i = 1'b0;
        fetch_group(32'h8000_0004, 32'h1111_1111, 32'h2222_2222, 1);

        // Flush during WAIT: response squashed, no request while discarding.
        @(negedge clk);
        icache_ack_i = 1'b1;
        #1;
        check_eq("req_addr_seq", icache_addr_o, 32'h8000_0008);
        @(negedge clk);
        icache_ack_i = 1'b0;
        flush_i      = 1'b1;
        flush_pc_i   = 32'h1000_0003;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        check_eq("discard_no_req0", 32'(icache_req_o), 32'd0);
        @(negedge clk);
        #1;
        check_eq("discard_no_req1", 32'(icache_req_o), 32'd0);
        @(negedge clk);
        icache_rvalid_i = 1'b1;
        icache_rdata1_i = 32'hDEAD_DEAD;
        @(negedge clk);
        icache_rvalid_i = 1'b0;
        fetch_group(32'h1000_0000, 32'h3333_3333, 32'h4444_4444, 2);

        // Flush coincident with rvalid.
        @(negedge clk);
        icache_ack_i = 1'b1;
        #1;
        check_eq("req_addr_seq2", icache_addr_o, 32'h1000_0008);
        @(negedge clk);
        icache_ack_i = 1'b0;
        @(negedge clk);
        flush_i         = 1'b1;
        flush_pc_i      = 32'h2000_0000;
        icache_rvalid_i = 1'b1;
        icache_rdata1_i = 32'hBAD0_BAD0;
        @(negedge clk);
        flush_i         = 1'b0;
        icache_rvalid_i = 1'b0;
        #1;
        check_eq("req_after_flush_rvalid", 32'(icache_req_o), 32'd1);
        check_eq("addr_after_flush_rvalid", icache_addr_o, 32'h2000_0000);

        // Back-pressure blocks requests but not delivery.
        buffer_full_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check_eq("full_blocks_req", 32'(icache_req_o), 32'd0);
        end
        @(negedge clk);
        buffer_full_i = 1'b0;
        icache_ack_i  = 1'b1;
        #1;
        check_eq("req_after_full", 32'(icache_req_o), 32'd1);
        check_eq("addr_after_full", icache_addr_o, 32'h2000_0000);
        @(negedge clk);
        icache_ack_i  = 1'b0;
        buffer_full_i = 1'b1;
        @(negedge clk);
        begin
            exp_t e;
            icache_rvalid_i = 1'b1;
            icache_rdata1_i = 32'h5555_5555;
            icache_rdata2_i = 32'h6666_6666;
            e.inst1 = 32'h5555_5555;
            e.inst2 = 32'h6666_6666;
            e.addr1 = 32'h2000_0000;
            e.addr2 = 32'h2000_0004;
            e.v2    = 1'b1;
            sb.push_back(e);
        end
        @(negedge clk);
        icache_rvalid_i = 1'b0;
        #1;
        check_eq("full_after_resp_no_req", 32'(icache_req_o), 32'd0);
        @(negedge clk);
        buffer_full_i = 1'b0;

        // Address wrap at the top of the space.
        flush_i    = 1'b1;
        flush_pc_i = 32'hFFFF_FFF8;
        @(negedge clk);
        flush_i = 1'b0;
        fetch_group(32'hFFFF_FFF8, 32'h7777_7777, 32'h8888_8888, 2);
        @(negedge clk);
        #1;
        check_eq("wrap_req", 32'(icache_req_o), 32'd1);
        check_eq("wrap_addr", icache_addr_o, 32'h0000_0000);

        // Reset mid-request returns to reset values.
        icache_ack_i = 1'b1;
        @(negedge clk);
        icache_ack_i = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("midrst_req", 32'(icache_req_o), 32'd0);
        check_eq("midrst_pc", icache_addr_o, 32'hBFC0_0000);
        check_eq("midrst_addr1", inst1_addr_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("post_rst_req", 32'(icache_req_o), 32'd1);

        repeat (3) @(negedge clk);
        check_eq("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
